// File: rtl/int_controller_pkg.sv
// Shared configuration for the interrupt controller: bus widths, register map,
// FSM state encoding and the source-to-code mapping.
package int_controller_pkg;

  localparam int XLEN           = 32;
  localparam int INT_CODE_WIDTH = 4;

  localparam logic [3:0] REG_ENABLE  = 4'h0;
  localparam logic [3:0] REG_PENDING = 4'h4;
  localparam logic [3:0] REG_CLAIM   = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_BUSY   = 2'd2
  } state_t;

  // Code 0 means "no interrupt", so source i is reported as i+1.
  function automatic logic [INT_CODE_WIDTH-1:0] src_code(input logic [INT_CODE_WIDTH-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// Register-window bus between a CSR-side master and the interrupt controller.
interface int_controller_if;
  import int_controller_pkg::*;

  logic [3:0]      reg_addr;
  logic [XLEN-1:0] reg_wdata;
  logic            reg_we;
  logic            reg_re;
  logic [XLEN-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/int_controller_rr_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_grant+1, wrapping at NUM_SRC-1.
module rr_picker #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge gateway into pending bits, ENABLE/PENDING/CLAIM
// register window and the claim/complete FSM driving int_code.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_src,
  int_controller_if.slave           bus,
  output logic [INT_CODE_WIDTH-1:0] int_code
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t                    state, state_nx;
  logic [NUM_SRC-1:0]        enable, pending, pending_nx, irq_prev, rise, clr_mask;
  logic [IDX_W-1:0]          winner, winner_nx, last_grant, last_grant_nx, pick_idx;
  logic [INT_CODE_WIDTH-1:0] int_code_nx, claim_val;
  logic                      pick_found;
  logic                      sel_enable, sel_pending, sel_claim;
  logic                      claim_rd, claim_wr, enable_wr;
  logic [NUM_SRC-1:0]        en_wdata;
  logic                      unused_wdata;

  assign sel_enable  = (bus.reg_addr == REG_ENABLE);
  assign sel_pending = (bus.reg_addr == REG_PENDING);
  assign sel_claim   = (bus.reg_addr == REG_CLAIM);
  assign claim_rd    = bus.reg_re && sel_claim;
  assign claim_wr    = bus.reg_we && sel_claim;
  assign enable_wr   = bus.reg_we && sel_enable;
  assign en_wdata    = bus.reg_wdata[NUM_SRC-1:0];
  assign unused_wdata = ^bus.reg_wdata;

  // Level lines become one-shot pending requests on their rising edge.
  assign rise       = irq_src & ~irq_prev;
  assign pending_nx = (pending & ~clr_mask) | rise;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (pending & enable),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    state_nx      = state;
    int_code_nx   = int_code;
    winner_nx     = winner;
    last_grant_nx = last_grant;
    clr_mask      = '0;
    claim_val     = '0;
    case (state)
      ST_IDLE: begin
        int_code_nx = '0;
        if (pick_found) begin
          state_nx    = ST_ASSERT;
          winner_nx   = pick_idx;
          int_code_nx = src_code(INT_CODE_WIDTH'(pick_idx));
        end
      end
      ST_ASSERT: begin
        // A claim read outranks a simultaneous mask of the winner.
        if (claim_rd) begin
          claim_val        = src_code(INT_CODE_WIDTH'(winner));
          clr_mask[winner] = 1'b1;
          int_code_nx      = '0;
          state_nx         = ST_BUSY;
        end else if (enable_wr && !en_wdata[winner]) begin
          int_code_nx = '0;
          state_nx    = ST_IDLE;
        end
      end
      ST_BUSY: begin
        int_code_nx = '0;
        if (claim_wr && (bus.reg_wdata[INT_CODE_WIDTH-1:0] == src_code(INT_CODE_WIDTH'(winner)))) begin
          last_grant_nx = winner;
          state_nx      = ST_IDLE;
        end
      end
      default: begin
        int_code_nx = '0;
        state_nx    = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.reg_rdata = '0;
    if (sel_enable)       bus.reg_rdata = XLEN'(enable);
    else if (sel_pending) bus.reg_rdata = XLEN'(pending);
    else if (sel_claim)   bus.reg_rdata = XLEN'(claim_val);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      int_code   <= '0;
      winner     <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      enable     <= '0;
      pending    <= '0;
      irq_prev   <= '0;
    end else begin
      state      <= state_nx;
      int_code   <= int_code_nx;
      winner     <= winner_nx;
      last_grant <= last_grant_nx;
      pending    <= pending_nx;
      irq_prev   <= irq_src;
      if (enable_wr) enable <= en_wdata;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: expectations are queued as stimulus is
// applied and popped against int_code / reg_rdata when the DUT responds.
module tb_int_controller;
  import int_controller_pkg::*;

  localparam int NUM_SRC = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        irq_src;
  logic [INT_CODE_WIDTH-1:0] int_code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] val;
  } exp_t;
  exp_t sb_q[$];

  int_controller_if bus();

  int_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .bus      (bus),
    .int_code (int_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [XLEN-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [XLEN-1:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow: got empty queue expected an entry (observed 0x%0h)", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, act, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [XLEN-1:0] exp);
    sb_push(tag, exp);
    bus.reg_addr = a;
    bus.reg_re   = 1'b1;
    #1;
    sb_pop(bus.reg_rdata);
    cyc();
    bus.reg_re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [XLEN-1:0] v);
    bus.reg_addr  = a;
    bus.reg_wdata = v;
    bus.reg_we    = 1'b1;
    cyc();
    bus.reg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    irq_src       = '0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.reg_we    = 1'b0;
    bus.reg_re    = 1'b0;
    repeat (2) cyc();

    // Reset state
    sb_push("rst_code", 0);
    sb_pop(XLEN'(int_code));
    rd("rst_enable", REG_ENABLE, 0);
    rd("rst_pending", REG_PENDING, 0);
    rst = 1'b1;
    cyc();
    rd("unmapped", 4'hC, 0);

    // Single source: edge to code in two cycles, claim, complete
    wr(REG_ENABLE, 32'hFF);
    rd("enable_rb", REG_ENABLE, 32'hFF);
    irq_src[3] = 1'b1;
    sb_push("a_code_1cyc", 0);
    sb_push("a_code_2cyc", 4);
    cyc();
    irq_src[3] = 1'b0;
    sb_pop(XLEN'(int_code));
    cyc();
    sb_pop(XLEN'(int_code));
    rd("a_claim", REG_CLAIM, 4);
    sb_push("a_code_after_claim", 0);
    sb_pop(XLEN'(int_code));
    rd("a_pending", REG_PENDING, 0);
    rd("a_claim_in_busy", REG_CLAIM, 0);
    wr(REG_CLAIM, 4);
    rd("idle_claim", REG_CLAIM, 0);

    // Round-robin order from a fresh reset (last_grant = 7)
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    wr(REG_ENABLE, 32'hFF);
    irq_src = 8'h22;
    sb_push("b_first", 2);
    cyc();
    irq_src = '0;
    cyc();
    sb_pop(XLEN'(int_code));
    rd("b_claim1", REG_CLAIM, 2);
    wr(REG_CLAIM, 2);
    sb_push("b_second", 6);
    cyc();
    sb_pop(XLEN'(int_code));
    rd("b_claim2", REG_CLAIM, 6);
    wr(REG_CLAIM, 6);
    irq_src[1] = 1'b1;
    sb_push("b_third", 2);
    cyc();
    irq_src[1] = 1'b0;
    cyc();
    sb_pop(XLEN'(int_code));
    rd("b_claim3", REG_CLAIM, 2);
    wr(REG_CLAIM, 2);

    // Wrong complete is ignored; BUSY blocks new winners
    irq_src[3] = 1'b1;
    sb_push("c_code", 4);
    cyc();
    irq_src[3] = 1'b0;
    cyc();
    sb_pop(XLEN'(int_code));
    irq_src[6] = 1'b1;
    rd("c_claim", REG_CLAIM, 4);
    irq_src[6] = 1'b0;
    wr(REG_CLAIM, 3);
    sb_push("c_wrong_complete", 0);
    sb_pop(XLEN'(int_code));
    cyc();
    sb_push("c_busy_hold", 0);
    sb_pop(XLEN'(int_code));
    rd("c_pending", REG_PENDING, 32'h40);
    wr(REG_CLAIM, 4);
    sb_push("c_next", 7);
    cyc();
    sb_pop(XLEN'(int_code));
    rd("c_claim6", REG_CLAIM, 7);
    wr(REG_CLAIM, 7);

    // Masking the winner while asserted drops back to IDLE, pending kept
    irq_src[1] = 1'b1;
    sb_push("d_code", 2);
    cyc();
    irq_src[1] = 1'b0;
    cyc();
    sb_pop(XLEN'(int_code));
    wr(REG_ENABLE, 32'hFD);
    sb_push("d_masked", 0);
    sb_pop(XLEN'(int_code));
    rd("d_pending", REG_PENDING, 32'h02);
    rd("d_enable", REG_ENABLE, 32'hFD);
    wr(REG_ENABLE, 32'hFF);
    sb_push("d_reassert", 2);
    cyc();
    sb_pop(XLEN'(int_code));
    wr(REG_PENDING, 32'h0);
    rd("d_pending_wr_ignored", REG_PENDING, 32'h02);
    rd("d_claim", REG_CLAIM, 2);
    wr(REG_CLAIM, 2);

    // Rising edge coinciding with the claim clear: set wins
    irq_src[2] = 1'b1;
    sb_push("e_code", 3);
    cyc();
    irq_src[2] = 1'b0;
    cyc();
    sb_pop(XLEN'(int_code));
    irq_src[2] = 1'b1;
    rd("e_claim", REG_CLAIM, 3);
    rd("e_pending", REG_PENDING, 32'h04);
    wr(REG_CLAIM, 3);
    sb_push("e_again", 3);
    cyc();
    sb_pop(XLEN'(int_code));
    rd("e_claim2", REG_CLAIM, 3);

    // Reset in BUSY, then a source held high through release
    rst = 1'b0;
    #1;
    sb_push("f_code_rst", 0);
    sb_pop(XLEN'(int_code));
    rd("f_enable", REG_ENABLE, 0);
    rd("f_pending", REG_PENDING, 0);
    irq_src = 8'h01;
    cyc();
    rst = 1'b1;
    wr(REG_ENABLE, 32'h01);
    sb_push("f_code", 1);
    cyc();
    sb_pop(XLEN'(int_code));

    chk("sb_drain", XLEN'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_SRC, default 8, number of peripheral interrupt sources; NUM_SRC+1 SHALL fit in `INT_CODE_WIDTH bits.
REQ-002 clk  input  1  single core clock; all state SHALL be synchronous to it.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 irq_src  input  NUM_SRC  level interrupt lines from peripherals, synchronous to clk.
REQ-005 reg_addr  input  4  byte offset of the register window: 0x0 ENABLE, 0x4 PENDING, 0x8 CLAIM.
REQ-006 reg_wdata  input  `XLEN  write data.
REQ-007 reg_we  input  1  write strobe, one cycle per access.
REQ-008 reg_re  input  1  read strobe, one cycle per access; a read of CLAIM has side effects.
REQ-009 reg_rdata  output  `XLEN  combinational read data, valid in the same cycle as reg_re; 0 for unmapped offsets.
REQ-010 int_code  output  `INT_CODE_WIDTH  active code to the CSR file peripheral input; 0 = none, source i = i+1.

Function
REQ-011 Gateway: pending[i] SHALL set on the cycle after irq_src[i] rises (0->1 against its registered previous value), independent of enable.
REQ-012 pending[i] SHALL clear only on a successful CLAIM read that returns i+1; if a rising edge of source i coincides with that clear, set SHALL win.
REQ-013 ENABLE write SHALL load enable[NUM_SRC-1:0] from reg_wdata; ENABLE read returns it zero-extended; PENDING read returns pending zero-extended; PENDING writes SHALL be ignored.
REQ-014 FSM states: IDLE, ASSERT, BUSY.
REQ-015 IDLE: int_code = 0; if (pending & enable) != 0, SHALL select winner by round-robin: first set bit scanning upward from last_grant+1, wrapping past NUM_SRC-1 to 0; next state ASSERT with int_code = winner+1 registered.
REQ-016 Latency: int_code SHALL become nonzero exactly 1 cycle after (pending & enable) becomes nonzero in IDLE.
REQ-017 ASSERT: int_code held = winner+1 until exit; winner SHALL NOT change even if higher-order sources become pending.
REQ-018 ASSERT + CLAIM read: reg_rdata = winner+1, clear pending[winner], int_code -> 0 next cycle, next state BUSY.
REQ-019 ASSERT + enable[winner] cleared by ENABLE write: next state IDLE, int_code -> 0, pending[winner] retained.
REQ-020 BUSY: int_code = 0; CLAIM read SHALL return 0 without side effects; new winners SHALL NOT be selected.
REQ-021 BUSY + CLAIM write with reg_wdata[`INT_CODE_WIDTH-1:0] == winner+1: last_grant = winner, next state IDLE; any other value SHALL be ignored (stay BUSY).
REQ-022 CLAIM read in IDLE SHALL return 0; CLAIM write in IDLE or ASSERT SHALL be ignored.
REQ-023 Simultaneous reg_re and reg_we SHALL perform the write and the read; CLAIM read side effects take priority over CLAIM write in the same cycle.

Reset
REQ-024 On rst low: state = IDLE, int_code = 0, enable = 0, pending = 0, irq_src previous register = 0, winner = 0, last_grant = NUM_SRC-1 (first scan starts at source 0).
REQ-025 Reset asserted mid-ASSERT or mid-BUSY SHALL abandon the transaction; no claim or complete is remembered.
REQ-026 A source held high through reset release SHALL register as a rising edge in the first clocked cycle.

Structure
REQ-027 Register offsets, FSM state encodings and the code-of-source mapping (i+1) SHALL be defined in the shared config include beside `XLEN and `INT_CODE_WIDTH.
REQ-028 The round-robin selector SHALL be one sub-module, rr_picker (inputs request vector and last_grant; outputs found flag and index), purely combinational.
REQ-029 The top SHALL contain the gateway, the register window and the FSM.

Verification
REQ-030 ENABLE=0xFF, pulse irq_src[3] -> int_code = 4 two cycles after the edge; CLAIM read returns 4; int_code = 0 next cycle; PENDING = 0.
REQ-031 Sources 1 and 5 pending, last_grant = 7 -> grant order 2, 6 across two claim/complete cycles; then raise 1 again with last_grant = 5 -> code 2.
REQ-032 In BUSY with winner code 4, write CLAIM = 3 -> stays BUSY, no new int_code; write CLAIM = 4 -> IDLE; pending source 6 then gives int_code = 7 one cycle later.
REQ-033 In ASSERT with code 2, write ENABLE = 0xFD -> int_code = 0 next cycle, PENDING bit 1 still set; re-enable -> int_code = 2 again.
REQ-034 Rising edge of irq_src[2] in the same cycle its claim read clears pending[2] -> PENDING bit 2 = 1 afterwards.
REQ-035 Assert rst during BUSY -> int_code = 0, ENABLE = 0, PENDING = 0 immediately; after release with irq_src[0] high and ENABLE = 0x01 -> int_code = 1.
